// File: rtl/master_rd_sink.sv
`default_nettype none
// ============================================================================
// Module   : master_rd_sink
// Brief    : PCI master read-path sink. Captures read data words into a FWFT
//            FIFO and tracks transfer progress across retries and disconnects.
//            Optional byte swap on capture: MASTER_RD_SINK_BSWAP_EN.
// Revision : 1.0
// ============================================================================
module master_rd_sink #(
    parameter int AW        = 4,
    parameter int LEN_W     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic [31:0]      adio_out,
    input  logic             m_data,
    input  logic             m_data_vld,
    input  logic             m_addr_n,
    input  logic             m_wrdn,
    input  logic [39:0]      csr,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_af,
    output logic [LEN_W-1:0] words_rcvd,
    output logic             done,
    output logic             fatal_err,
    output logic             retry_seen,
    output logic             overflow
);

    localparam logic [AW:0] c_DEPTH  = (AW+1)'(2**AW);
    localparam logic [AW:0] c_MARGIN = (AW+1)'(AF_MARGIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic             fatal_err_q, fatal_err_d;
    logic             retry_q, retry_d;
    logic             ovf_q, ovf_d;
    logic             abort_q;
    logic             m_data_q;
    logic             af_q;
    logic [AW:0]      wptr_q, rptr_q;
    logic [31:0]      mem_q [2**AW];

    logic [AW:0]      w_count, w_count_nxt;
    logic             w_empty, w_full, w_pop, w_push, w_capture;
    logic [31:0]      w_wdata;
    logic             unused_csr;

    assign unused_csr = ^{csr[37:0]};

`ifdef MASTER_RD_SINK_BSWAP_EN
    assign w_wdata = {adio_out[7:0], adio_out[15:8], adio_out[23:16], adio_out[31:24]};
`else
    assign w_wdata = adio_out;
`endif

    assign w_count     = wptr_q - rptr_q;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == c_DEPTH);
    assign w_pop       = rd_ready & ~w_empty;
    assign w_capture   = (state_q == S_DATA) & m_data_vld & (words_q < len_q);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push      = w_capture & (~w_full | w_pop);
    assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        fatal_err_d = fatal_err_q;
        retry_d     = retry_q;
        ovf_d       = ovf_q;

        if (w_capture) begin
            words_d = words_q + LEN_W'(1);
            if (!w_push) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d     = S_ARM;
                    len_d       = (xfer_len == '0) ? LEN_W'(1) : xfer_len;
                    words_d     = '0;
                    fatal_err_d = 1'b0;
                    retry_d     = 1'b0;
                    ovf_d       = 1'b0;
                end
            end
            S_ARM: begin
                if (!m_addr_n && !m_wrdn) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_data) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (m_data_q && !m_data) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (words_q == len_q) begin
                    state_d = S_DONE;
                end else if (abort_q) begin
                    state_d     = S_ERR;
                    fatal_err_d = 1'b1;
                end else begin
                    state_d = S_ARM;
                    retry_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            words_q     <= '0;
            fatal_err_q <= 1'b0;
            retry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
            m_data_q    <= 1'b0;
            af_q        <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            fatal_err_q <= fatal_err_d;
            retry_q     <= retry_d;
            ovf_q       <= ovf_d;
            m_data_q    <= m_data;
            af_q        <= (c_DEPTH - w_count_nxt) <= c_MARGIN;
            wptr_q      <= wptr_q + (AW+1)'(w_push);
            rptr_q      <= rptr_q + (AW+1)'(w_pop);
            // Abort status is per bus cycle: a new address phase clears it.
            if (!m_addr_n) begin
                abort_q <= 1'b0;
            end else if (m_data && (csr[39] || csr[38])) begin
                abort_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wptr_q[AW-1:0]] <= w_wdata;
        end
    end

    assign rd_valid   = ~w_empty;
    assign rd_data    = w_empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign rd_af      = af_q;
    assign words_rcvd = words_q;
    assign done       = (state_q == S_DONE);
    assign fatal_err  = fatal_err_q;
    assign retry_seen = retry_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_master_rd_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_rd_sink
// Brief    : Directed bench for master_rd_sink with AW = 4, 3 and 2 instances
//            sharing one stimulus stream. Honours MASTER_RD_SINK_BSWAP_EN.
// Revision : 1.0
// ============================================================================
module tb_master_rd_sink;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  xfer_len = '0;
    logic [31:0] adio_out = '0;
    logic        m_data = 1'b0;
    logic        m_data_vld = 1'b0;
    logic        m_addr_n = 1'b1;
    logic        m_wrdn = 1'b0;
    logic [39:0] csr = '0;
    logic        rd_ready = 1'b0;

    logic [31:0] rd_data4, rd_data3, rd_data2;
    logic        rd_valid4, rd_valid3, rd_valid2;
    logic        rd_af4, rd_af3, rd_af2;
    logic [7:0]  words4, words3, words2;
    logic        done4, done3, done2;
    logic        fatal4, fatal3, fatal2;
    logic        retry4, retry3, retry2;
    logic        ovf4, ovf3, ovf2;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    master_rd_sink #(.AW(4), .LEN_W(8), .AF_MARGIN(2)) u4 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .xfer_len(xfer_len),
        .adio_out(adio_out), .m_data(m_data), .m_data_vld(m_data_vld),
        .m_addr_n(m_addr_n), .m_wrdn(m_wrdn), .csr(csr),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_ready(rd_ready),
        .rd_af(rd_af4), .words_rcvd(words4), .done(done4),
        .fatal_err(fatal4), .retry_seen(retry4), .overflow(ovf4));

    master_rd_sink #(.AW(3), .LEN_W(8), .AF_MARGIN(2)) u3 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .xfer_len(xfer_len),
        .adio_out(adio_out), .m_data(m_data), .m_data_vld(m_data_vld),
        .m_addr_n(m_addr_n), .m_wrdn(m_wrdn), .csr(csr),
        .rd_data(rd_data3), .rd_valid(rd_valid3), .rd_ready(rd_ready),
        .rd_af(rd_af3), .words_rcvd(words3), .done(done3),
        .fatal_err(fatal3), .retry_seen(retry3), .overflow(ovf3));

    master_rd_sink #(.AW(2), .LEN_W(8), .AF_MARGIN(2)) u2 (
        .CLK(CLK), .reset_n(reset_n), .start(start), .xfer_len(xfer_len),
        .adio_out(adio_out), .m_data(m_data), .m_data_vld(m_data_vld),
        .m_addr_n(m_addr_n), .m_wrdn(m_wrdn), .csr(csr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_ready(rd_ready),
        .rd_af(rd_af2), .words_rcvd(words2), .done(done2),
        .fatal_err(fatal2), .retry_seen(retry2), .overflow(ovf2));

    function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef MASTER_RD_SINK_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [7:0] len);
        start = 1'b1; xfer_len = len; cyc(); start = 1'b0;
    endtask

    task automatic addr_phase(input logic wr);
        m_addr_n = 1'b0; m_wrdn = wr; cyc(); m_addr_n = 1'b1; m_wrdn = 1'b0;
    endtask

    task automatic data_begin();
        m_data = 1'b1; cyc();
    endtask

    task automatic word(input logic [31:0] w, input logic pop);
        m_data_vld = 1'b1; adio_out = w; rd_ready = pop; cyc();
        m_data_vld = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic data_end();
        m_data = 1'b0; cyc();
    endtask

    task automatic pop();
        rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    endtask

    task automatic drain();
        rd_ready = 1'b1; repeat (20) cyc(); rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) cyc();
        chk("rst_valid", 32'(rd_valid4), 32'd0);
        chk("rst_data", rd_data4, 32'd0);
        chk("rst_words", 32'(words4), 32'd0);
        chk("rst_flags", 32'({rd_af4, done4, fatal4, retry4, ovf4}), 32'd0);
        reset_n = 1'b1;
        cyc();

        // Single read
        do_start(8'd1);
        addr_phase(1'b0);
        data_begin();
        word(32'hDEADBEEF, 1'b0);
        chk("single_valid", 32'(rd_valid4), 32'd1);
        chk("single_data", rd_data4, xf(32'hDEADBEEF));
        data_end();
        chk("single_nodone_check", 32'(done4), 32'd0);
        cyc();
        chk("single_done", 32'(done4), 32'd1);
        cyc();
        chk("single_done_pulse", 32'(done4), 32'd0);
        chk("single_words", 32'(words4), 32'd1);
        chk("single_sticky", 32'({fatal4, retry4, ovf4}), 32'd0);
        pop();
        chk("single_empty", 32'(rd_valid4), 32'd0);
        drain();

        // Burst of 8 with no pops: AW=4 never almost-full, AW=3 from count 6
        do_start(8'd8);
        addr_phase(1'b0);
        data_begin();
        for (int i = 0; i < 8; i++) begin
            word(32'h100 + 32'(i), 1'b0);
            chk("burst_af4", 32'(rd_af4), 32'd0);
            chk("burst_af3", 32'(rd_af3), (i >= 5) ? 32'd1 : 32'd0);
        end
        data_end();
        cyc();
        chk("burst_done", 32'(done4), 32'd1);
        chk("burst_words", 32'(words4), 32'd8);
        chk("burst_ovf4", 32'(ovf4), 32'd0);
        chk("burst_ovf2", 32'(ovf2), 32'd1);
        chk("burst_words2", 32'(words2), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("burst_pop", rd_data4, xf(32'h100 + 32'(i)));
            pop();
        end
        chk("burst_empty", 32'(rd_valid4), 32'd0);
        drain();

        // Overflow on AW=2, including write+pop while full
        do_start(8'd6);
        chk("ovf_cleared", 32'(ovf2), 32'd0);
        addr_phase(1'b0);
        data_begin();
        for (int i = 0; i < 4; i++) word(32'h200 + 32'(i), 1'b0);
        chk("ovf_full_noovf", 32'(ovf2), 32'd0);
        chk("ovf_full_af", 32'(rd_af2), 32'd1);
        word(32'h204, 1'b1);
        chk("ovf_wr_pop_full", 32'(ovf2), 32'd0);
        word(32'h205, 1'b0);
        chk("ovf_set", 32'(ovf2), 32'd1);
        chk("ovf_words", 32'(words2), 32'd6);
        data_end();
        cyc();
        chk("ovf_done", 32'(done2), 32'd1);
        for (int i = 1; i < 5; i++) begin
            chk("ovf_pop", rd_data2, xf(32'h200 + 32'(i)));
            pop();
        end
        chk("ovf_empty", 32'(rd_valid2), 32'd0);
        drain();

        // Retry split: 2 words, disconnect, 2 more words
        do_start(8'd4);
        addr_phase(1'b0);
        data_begin();
        word(32'hA0, 1'b0);
        word(32'hA1, 1'b0);
        csr[36] = 1'b1;
        data_end();
        csr = '0;
        cyc();
        chk("retry_seen", 32'(retry4), 32'd1);
        chk("retry_nodone", 32'(done4), 32'd0);
        chk("retry_words", 32'(words4), 32'd2);
        addr_phase(1'b0);
        data_begin();
        word(32'hA2, 1'b0);
        word(32'hA3, 1'b0);
        data_end();
        cyc();
        chk("retry_done", 32'(done4), 32'd1);
        chk("retry_words_final", 32'(words4), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("retry_pop", rd_data4, xf(32'hA0 + 32'(i)));
            pop();
        end
        drain();

        // Fatal abort
        do_start(8'd4);
        addr_phase(1'b0);
        csr[38] = 1'b1;
        data_begin();
        word(32'hF0, 1'b0);
        data_end();
        csr = '0;
        cyc();
        chk("fatal_set", 32'(fatal4), 32'd1);
        chk("fatal_noretry", 32'(retry4), 32'd0);
        repeat (3) begin
            chk("fatal_nodone", 32'(done4), 32'd0);
            cyc();
        end
        // Restart from ERR with length 0 (treated as 1); write address ignored
        do_start(8'd0);
        chk("fatal_cleared", 32'(fatal4), 32'd0);
        chk("restart_words", 32'(words4), 32'd0);
        addr_phase(1'b1);
        data_begin();
        word(32'h999, 1'b0);
        data_end();
        chk("wr_addr_ignored", 32'(words4), 32'd0);
        addr_phase(1'b0);
        data_begin();
        word(32'hB0, 1'b0);
        word(32'hB1, 1'b0);
        chk("len0_saturate", 32'(words4), 32'd1);
        data_end();
        cyc();
        chk("len0_done", 32'(done4), 32'd1);
        chk("len0_noovf", 32'(ovf4), 32'd0);
        chk("fatal_head", rd_data4, xf(32'hF0));
        pop();
        chk("len0_head", rd_data4, xf(32'hB0));
        pop();
        chk("len0_empty", 32'(rd_valid4), 32'd0);

        // Asynchronous reset mid-burst
        do_start(8'd8);
        addr_phase(1'b0);
        data_begin();
        for (int i = 0; i < 3; i++) word(32'h300 + 32'(i), 1'b0);
        chk("pre_reset_words", 32'(words4), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rd_valid4), 32'd0);
        chk("async_rst_words", 32'(words4), 32'd0);
        m_data = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        // Byte order check
        do_start(8'd1);
        addr_phase(1'b0);
        data_begin();
        word(32'h11223344, 1'b0);
`ifdef MASTER_RD_SINK_BSWAP_EN
        chk("bswap_data", rd_data4, 32'h44332211);
`else
        chk("bswap_data", rd_data4, 32'h11223344);
`endif
        data_end();
        cyc();
        chk("final_done", 32'(done4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
